// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding, grant owner,
// parameter defaults and small arbitration helpers.
package memory_arbiter_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;
    localparam int DEFAULT_LATENCY   = 2;
    localparam int CNT_W             = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_ACC = 2'd1,
        ST_D_ACC = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

    // Data wins unless both ports wait and data had the previous grant.
    function automatic logic grant_data_first(input logic d_req, input logic i_req,
                                              input grant_e last_grant);
        return d_req && !(i_req && (last_grant == GRANT_DATA));
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
// master = requesters plus memory side, slave = the arbiter itself.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 i_ready;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_data;
    logic                 d_ready;
    logic                 m_readM;
    logic                 m_writeM;
    logic [WORD_SIZE-1:0] m_address;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;
    logic                 stall;

    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        input  i_data, i_ready, d_data, d_ready, m_readM, m_writeM, m_address, m_wdata, stall
    );

    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
        output i_data, i_ready, d_data, d_ready, m_readM, m_writeM, m_address, m_wdata, stall
    );

endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter in front of a fixed-latency memory with
// alternating priority when both ports wait, and one idle cycle between accesses.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int LATENCY   = DEFAULT_LATENCY
) (
    input  logic            clk,
    input  logic            reset_n,
    memory_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0]     CNT_LOAD  = latency_load(LATENCY);
    localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [WORD_SIZE-1:0] WORD_ZERO = {WORD_SIZE{1'b0}};

    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    grant_e               last_q, last_d;
    logic                 m_read_q, m_read_d;
    logic                 m_write_q, m_write_d;
    logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
    logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
    logic                 i_ready_q, i_ready_d;
    logic                 d_ready_q, d_ready_d;
    logic [WORD_SIZE-1:0] i_data_q, i_data_d;
    logic [WORD_SIZE-1:0] d_data_q, d_data_d;
    logic                 d_req_s;
    logic                 i_req_s;

    assign d_req_s = bus.d_readM | bus.d_writeM;
    assign i_req_s = bus.i_readM;

    // Next-state: arbitration and latching in IDLE, latency countdown in the access states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_data_d  = i_data_q;
        d_data_d  = d_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_data_first(d_req_s, i_req_s, last_q)) begin
                    state_d   = ST_D_ACC;
                    cnt_d     = CNT_LOAD;
                    last_d    = GRANT_DATA;
                    m_addr_d  = bus.d_address;
                    m_wdata_d = bus.d_wdata;
                    // Read and write together is a store.
                    m_write_d = bus.d_writeM;
                    m_read_d  = ~bus.d_writeM;
                    d_ready_d = (CNT_LOAD == CNT_ZERO);
                end else if (i_req_s) begin
                    state_d   = ST_I_ACC;
                    cnt_d     = CNT_LOAD;
                    last_d    = GRANT_INSTR;
                    m_addr_d  = bus.i_address;
                    m_wdata_d = WORD_ZERO;
                    m_write_d = 1'b0;
                    m_read_d  = 1'b1;
                    i_ready_d = (CNT_LOAD == CNT_ZERO);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_ACC, ST_D_ACC: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d   = ST_IDLE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    m_addr_d  = WORD_ZERO;
                    m_wdata_d = WORD_ZERO;
                    if (state_q == ST_I_ACC) begin
                        i_data_d = bus.m_rdata;
                    end else begin
                        d_data_d = bus.m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        i_ready_d = (state_q == ST_I_ACC);
                        d_ready_d = (state_q == ST_D_ACC);
                    end else begin
                        i_ready_d = 1'b0;
                        d_ready_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                m_addr_d  = WORD_ZERO;
                m_wdata_d = WORD_ZERO;
            end
        endcase
    end

    // State, counter and all output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            last_q    <= GRANT_INSTR;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= WORD_ZERO;
            m_wdata_q <= WORD_ZERO;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_data_q  <= WORD_ZERO;
            d_data_q  <= WORD_ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_data_q  <= i_data_d;
            d_data_q  <= d_data_d;
        end
    end

    assign bus.m_readM   = m_read_q;
    assign bus.m_writeM  = m_write_q;
    assign bus.m_address = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_data    = i_data_q;
    assign bus.d_data    = d_data_q;
    // Held at 0 while in reset so every output reads 0 then.
    assign bus.stall     = reset_n & ((i_req_s & ~i_ready_q) | (d_req_s & ~d_ready_q));

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width.
REQ-002 Parameter LATENCY, default 2, memory cycles per access (legal range 1..7).
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low, named reset_n.
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_readM  in  1  instruction fetch request, level.
- i_address  in  WORD_SIZE  fetch address.
- i_data  out  WORD_SIZE  fetched word.
- i_ready  out  1  one-cycle fetch-done pulse.
- d_readM  in  1  data load request, level.
- d_writeM  in  1  data store request, level.
- d_address  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  store data.
- d_data  out  WORD_SIZE  loaded word.
- d_ready  out  1  one-cycle data-done pulse.
- m_readM  out  1  memory read strobe.
- m_writeM  out  1  memory write strobe.
- m_address  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data, valid in the final access cycle.
- stall  out  1  combinational; high when any request is pending and its ready is not asserted this cycle.

Function
REQ-005 The FSM SHALL have states IDLE, I_ACC and D_ACC; state and counter update on the rising edge of clk.
REQ-006 In IDLE, a data request (d_readM or d_writeM) SHALL go to D_ACC; otherwise i_readM SHALL go to I_ACC; otherwise the FSM SHALL stay in IDLE.
REQ-007 When both request types are pending in IDLE and the last grant was data, the grant SHALL go to I_ACC (alternation); otherwise the grant SHALL go to D_ACC.
REQ-008 On entering an access state, the address and write data SHALL be latched; m_* outputs SHALL be driven from the latched values for exactly LATENCY cycles.
REQ-009 A 3-bit counter SHALL load LATENCY-1 on grant and decrement each cycle; when it reaches 0, ready SHALL pulse for that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-010 i_data / d_data SHALL register m_rdata in the ready cycle and hold it until the next completion on the same port.
REQ-011 d_readM and d_writeM both high SHALL be treated as a write; m_readM=0 during that access.
REQ-012 A request deasserted mid-access SHALL NOT abort the access; the access completes and ready still pulses.
REQ-013 Minimum turnaround: one IDLE cycle between consecutive accesses; throughput is one access per LATENCY+1 cycles.
REQ-014 Requesters SHALL hold requests, address and data until ready (requester obligation; the block does not re-sample them after grant).

Reset
REQ-015 With reset_n=0, asynchronously: state=IDLE, counter=0, last-grant=instruction, all m_* outputs=0, i_ready=d_ready=0, i_data=d_data=0.
REQ-016 Reset mid-access SHALL drop the access silently, with no ready pulse.
REQ-017 The first grant after reset with both requests pending SHALL go to data.

Structure
REQ-018 State encodings and the LATENCY default SHALL be defined in a shared constants include alongside the existing opcode and selector definitions.
REQ-019 The block SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-020 Fetch only: i_readM=1, i_address=0x0010, m_rdata=0xA5A5, LATENCY=2 -> m_readM high for 2 cycles; i_ready pulses on the 2nd cycle; i_data=0xA5A5.
REQ-021 Store: d_writeM=1, d_address=0x0040, d_wdata=0x1234 -> m_writeM=1, m_address=0x0040, m_wdata=0x1234 for 2 cycles; d_ready pulses once.
REQ-022 Simultaneous i_readM and d_readM from reset -> data served first, then one IDLE cycle, then the fetch; stall=1 throughout until i_ready.
REQ-023 Continuous i_readM and d_readM -> grants alternate D, I, D, I; neither port waits more than 2*(LATENCY+1) cycles.
REQ-024 reset_n pulled low in the 1st cycle of D_ACC -> all outputs 0 immediately; no d_ready; after release with d_readM held -> fresh full-latency access.
REQ-025 d_readM=d_writeM=1 -> write access only; m_readM stays 0.
